// File: rtl/gp2021_axil_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp handshake into AXI4-Lite
// write/read transactions, with a sticky timeout flag for unresponsive slaves.
module gp2021_axil_master #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        axi_clk,
    input  logic        axi_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic        timeout_err,
    input  logic        timeout_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [31:0] TMO = TIMEOUT_CYC[31:0];

    state_t      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        terr_q, terr_d;
    logic        run_s;

    // Transaction FSM next-state and datapath capture
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                else                            awvalid_d = awvalid_q;
                if (wvalid_q && m_axi_wready)   wvalid_d = 1'b0;
                else                            wvalid_d = wvalid_q;
                if (m_axi_bvalid) begin
                    rsp_resp_d  = m_axi_bresp;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (arvalid_q && m_axi_arready) arvalid_d = 1'b0;
                else                            arvalid_d = arvalid_q;
                if (m_axi_rvalid) begin
                    rsp_resp_d  = m_axi_rresp;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    arvalid_d   = 1'b0;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
                else           state_d = ST_RSP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign run_s = (state_q == ST_WR) || (state_q == ST_RD);

    // Timeout counter saturates at TMO; a fresh timeout beats a same-cycle clear
    always_comb begin
        tcnt_d = tcnt_q;
        terr_d = terr_q;
        if ((state_q == ST_IDLE) && cmd_valid) tcnt_d = 32'd0;
        else if (run_s && (tcnt_q != TMO))     tcnt_d = tcnt_q + 32'd1;
        else                                   tcnt_d = tcnt_q;
        if (run_s && (TMO != 32'd0) && (tcnt_q == TMO - 32'd1)) terr_d = 1'b1;
        else if (timeout_clr)                                   terr_d = 1'b0;
        else                                                    terr_d = terr_q;
    end

    // State and datapath registers
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'h0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_resp_q  <= 2'b00;
            tcnt_q      <= 32'd0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            tcnt_q      <= tcnt_d;
            terr_q      <= terr_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign rsp_valid     = (state_q == ST_RSP);
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_bready  = (state_q == ST_WR);
    assign m_axi_rready  = (state_q == ST_RD);
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_gp2021_axil_master.sv
// Directed bench for gp2021_axil_master; the bench plays the AXI4-Lite slave
// and the command/response client cycle by cycle.
module tb_gp2021_axil_master;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic        busy, timeout_err, timeout_clr;

    int total = 0;
    int bad   = 0;

    gp2021_axil_master #(.TIMEOUT_CYC(16)) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .busy(busy), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Minimum-latency transaction against an always-ready slave
    task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rd);
        chk("acc_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
        if (wr) begin
            chk("c1_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
            chk("c1_wvalid",  {31'd0, m_axi_wvalid},  32'd1);
            chk("c1_awaddr",  m_axi_awaddr, a);
            chk("c1_wdata",   m_axi_wdata,  d);
            chk("c1_wstrb",   {28'd0, m_axi_wstrb}, {28'd0, s});
            m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        end else begin
            chk("c1_arvalid", {31'd0, m_axi_arvalid}, 32'd1);
            chk("c1_araddr",  m_axi_araddr, a);
            m_axi_arready = 1'b1;
        end
        step();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        chk("c2_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'd0);
        chk("c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        if (wr) begin
            m_axi_bvalid = 1'b1; m_axi_bresp = resp;
        end else begin
            m_axi_rvalid = 1'b1; m_axi_rdata = rd; m_axi_rresp = resp;
        end
        step();
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
        chk("c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("c3_rsp_write", {31'd0, rsp_write}, {31'd0, wr});
        chk("c3_rsp_resp",  {30'd0, rsp_resp},  {30'd0, resp});
        chk("c3_rsp_rdata", rsp_rdata, wr ? 32'h0000_0000 : rd);
        chk("c3_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("c4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        axi_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b0; timeout_clr = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_rvalid = 1'b0;
        m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
        step(); step();
        axi_rst = 1'b0;
        step();

        // reset state
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_outputs", {24'd0, busy, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                            m_axi_arvalid, m_axi_bready, m_axi_rready, timeout_err}, 32'd0);
        chk("rst_awaddr", m_axi_awaddr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);

        // minimum write
        xact(1'b1, 32'h0000_0004, 32'h0000_0017, 4'hF, 2'b00, 32'd0);

        // skewed write: awready three cycles late, wready immediate
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0008;
        cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'h3;
        step();
        cmd_valid = 1'b0;
        m_axi_wready = 1'b1;
        chk("sk1_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
        chk("sk1_wvalid",  {31'd0, m_axi_wvalid},  32'd1);
        step();
        m_axi_wready = 1'b0;
        chk("sk2_wvalid",  {31'd0, m_axi_wvalid},  32'd0);
        chk("sk2_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
        step();
        chk("sk3_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
        chk("sk3_bready",  {31'd0, m_axi_bready},  32'd1);
        step();
        chk("sk4_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
        chk("sk4_awaddr",  m_axi_awaddr, 32'h0000_0008);
        chk("sk4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        m_axi_awready = 1'b1;
        step();
        m_axi_awready = 1'b0;
        chk("sk5_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        step();
        m_axi_bvalid = 1'b0;
        chk("sk6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sk6_rsp_write", {31'd0, rsp_write}, 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("sk7_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("sk8_single_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("sk8_cmd_ready",  {31'd0, cmd_ready}, 32'd1);

        // read with response backpressure and a stray B handshake in RD
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020;
        step();
        cmd_valid = 1'b0;
        chk("rd1_araddr", m_axi_araddr, 32'h0000_0020);
        m_axi_arready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
        step();
        m_axi_arready = 1'b0; m_axi_bvalid = 1'b0;
        chk("rd2_stray_b_ignored", {30'd0, rsp_valid, m_axi_rready}, 32'd1);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b00;
        step();
        m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_rsp_resp",  {30'd0, rsp_resp}, 32'd0);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_last_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        rsp_ready = 1'b0;
        chk("bp_after_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // error passthrough
        xact(1'b1, 32'h0000_0010, 32'h1234_0000, 4'h1, 2'b10, 32'd0);
        xact(1'b0, 32'h0000_0014, 32'd0, 4'h0, 2'b11, 32'h0BAD_F00D);

        // timeout: arready withheld
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i < 16; i++) step();
        chk("to16_err", {31'd0, timeout_err}, 32'd0);
        chk("to16_arvalid", {31'd0, m_axi_arvalid}, 32'd1);
        step();
        chk("to17_err", {31'd0, timeout_err}, 32'd1);
        chk("to17_arvalid", {31'd0, m_axi_arvalid}, 32'd1);
        step(); step();
        chk("to19_err", {31'd0, timeout_err}, 32'd1);
        chk("to19_arvalid", {31'd0, m_axi_arvalid}, 32'd1);
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        chk("to_late_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b00;
        step();
        m_axi_rvalid = 1'b0;
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        chk("to_err_cleared", {31'd0, timeout_err}, 32'd0);

        // reset in the middle of a write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        step();
        cmd_valid = 1'b0;
        chk("mr_awvalid_pre", {31'd0, m_axi_awvalid}, 32'd1);
        axi_rst = 1'b1;
        step();
        axi_rst = 1'b0;
        chk("mr_valids", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        step();
        chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        xact(1'b0, 32'h0000_0044, 32'd0, 4'h0, 2'b00, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gp2021_axil_master.md
# gp2021_axil_master

Single-outstanding AXI4-Lite master that turns a simple command/response handshake into AXI4-Lite write and read transactions. It is the initiator counterpart of the correlator's AXI4-Lite slave register interface. Hardware tracking-loop logic or a bench sequencer uses it to program channel controls (PRN, carrier and code NCO increments, slew) and to read dump and TIC data without a MicroBlaze. A timeout monitor flags a slave that never responds.

## Interface
Parameters:
- TIMEOUT_CYC, default 1024: number of cycles waiting on the AXI side before `timeout_err` sets. 0 disables the monitor.

Ports:
- axi_clk  in  1  single clock for all logic (AXI domain).
- axi_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP, passed through unchanged.
- m_axi_awaddr  out  32; m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  32; m_axi_wstrb  out  4; m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- m_axi_araddr  out  32; m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  32; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky timeout flag.
- timeout_clr  in  1  clears `timeout_err`.

## Operation
- FSM states: IDLE, WR, RD, RSP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr, wdata and wstrb.
  - Write: go to WR and set awvalid=wvalid=1. Read: go to RD and set arvalid=1.
- **WR:**
  - `awvalid` clears the cycle after an `awvalid&&awready` cycle. `wvalid` clears independently, the cycle after `wvalid&&wready`.
  - AW and W may complete in either order or in the same cycle.
  - `bready`=1 throughout WR.
  - On `bvalid&&bready`: capture bresp, set rsp_write=1, rsp_rdata=0, go to RSP.
- **RD:**
  - `arvalid` clears the cycle after an `arvalid&&arready` cycle.
  - `rready`=1 throughout RD.
  - On `rvalid&&rready`: capture rdata and rresp, set rsp_write=0, go to RSP.
- **RSP:**
  - `rsp_valid`=1 until `rsp_ready`, then return to IDLE.
  - rsp_* outputs are stable while `rsp_valid` is high.
- AXI valids never drop before their handshake, including after a timeout.
- Address, data and strobe outputs hold their latched values from acceptance until the handshake.
- Exactly one transaction is outstanding at any time.
- Timeout monitor:
  - Counter clears on command acceptance and increments each cycle in WR or RD.
  - When it reaches TIMEOUT_CYC: `timeout_err`<=1. The counter saturates.
  - The transaction keeps waiting.
  - `timeout_err` clears only on `timeout_clr` or `axi_rst`. If `timeout_clr` and a new timeout occur in the same cycle, set wins.
- Any AXI handshake outside the state that expects it is ignored. An example is bvalid in RD.

## Timing
- Values after `axi_rst`: state=IDLE; cmd_ready=1 from the first cycle after reset; every other output = 0, including all m_axi valids/readies, addr/data, rsp_*, busy and timeout_err.
- Reset mid-transaction aborts immediately. The bench/slave must also be reset.
- All AXI outputs are registered or decoded from state only. No combinational path from m_axi inputs to m_axi outputs.
- `cmd_ready` and `busy` are decoded from state. `rsp_valid` = (state==RSP).
- Minimum write, with an always-ready slave and bvalid one cycle after the AW/W handshake:
  - cycle 0: accept
  - cycle 1: AW/W handshake
  - cycle 2: B handshake
  - cycle 3: rsp_valid
  - cycle 4: cmd_ready again
- Minimum read follows the same pattern (AR handshake at cycle 1, R at 2, rsp_valid at 3). Command-to-command throughput is 4 cycles.

## Test plan
- **Write, always-ready slave:** write 0x04 ← 0x0000_0017, wstrb=0xF, BRESP=0.
  - awvalid/wvalid high in cycle 1 only.
  - rsp_valid in cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- **Skewed write:** awready delayed 3 cycles, wready immediate.
  - wvalid drops after cycle 1; awvalid holds until cycle 4.
  - B accepted only afterwards; exactly one response.
- **Read with backpressure:** read 0x20, slave returns 0xDEADBEEF, RRESP=0, rsp_ready held low 5 cycles.
  - rsp_valid held with stable rdata=0xDEADBEEF, rsp_resp=0.
  - cmd_ready=0 until the cycle after rsp_ready.
- **Error passthrough:** write answered with BRESP=2'b10 → rsp_resp=2'b10. Read answered with RRESP=2'b11 → rsp_resp=2'b11.
- **Timeout:** TIMEOUT_CYC=16, slave never asserts arready.
  - timeout_err rises after 16 cycles in RD; arvalid stays 1.
  - Late arready + rvalid still produces a response.
  - timeout_clr clears the flag.
- **Reset mid-write:** assert axi_rst while awvalid=1.
  - Next cycle: all m_axi valids=0, rsp_valid=0, busy=0.
  - Then cmd_ready=1; a fresh read completes normally.
